// File: rtl/lfsr_rand_pkg.sv
// Shared constants, state encoding and step function for the LFSR random arbiter.
package lfsr_rand_pkg;

    localparam int LFSR_W = 28;
    localparam int TAP_A  = 27;
    localparam int TAP_B  = 23;
    localparam int TAP_C  = 16;
    localparam int TAP_D  = 0;

    // XNOR feedback locks up in all-ones, so all-zero is a legal state.
    localparam logic [LFSR_W-1:0] LFSR_LOCK = 28'hFFFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        GRANT = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D])};
    endfunction

endpackage

// File: rtl/lfsr28_seedable.sv
// Free-running 28-bit XNOR LFSR with a seed load port that never admits the lock-up state.
module lfsr28_seedable
    import lfsr_rand_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else if (seed_load) begin
            state <= (seed == LFSR_LOCK) ? '0 : seed;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter handing out bounded random values from one shared LFSR,
// using rejection sampling with a capped number of draws per grant.
module lfsr_rand_arbiter
    import lfsr_rand_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int OUT_W     = 8,
    parameter int MAX_TRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seed_load,
    input  logic [LFSR_W-1:0]      seed,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*OUT_W-1:0]  bound,
    output logic [NREQ-1:0]        gnt,
    output logic                   rnd_valid,
    output logic [OUT_W-1:0]       rnd_data,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TRY_W = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    if (NREQ < 2 || NREQ > 8 || OUT_W < 1 || OUT_W > 16 || MAX_TRIES < 1) begin : g_bad_param
        $error("lfsr_rand_arbiter: unsupported parameter set");
    end

    logic [LFSR_W-1:0] lfsr;
    logic [OUT_W-1:0]  cand;
    logic              unused_lfsr_hi;

    lfsr28_seedable u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed      (seed),
        .state     (lfsr)
    );

    // Only the low OUT_W bits form a candidate; the rest just feed the shift chain.
    assign cand           = lfsr[OUT_W-1:0];
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:OUT_W];

    logic [OUT_W-1:0] bound_arr [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_bound
        assign bound_arr[i] = bound[i*OUT_W +: OUT_W];
    end

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [IDX_W-1:0] last, last_next;
    logic [OUT_W-1:0] bnd, bnd_next;
    logic [TRY_W-1:0] tries, tries_next;
    logic             accept;
    logic [OUT_W-1:0] accept_val;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] probe;

    // Search starts just after the last winner and wraps, so the last winner is checked last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        probe      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            probe = IDX_W'((int'(last) + k) % NREQ);
            if (!pick_found && req[probe]) begin
                pick_found = 1'b1;
                pick_idx   = probe;
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        last_next  = last;
        bnd_next   = bnd;
        tries_next = tries;
        accept     = 1'b0;
        accept_val = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    idx_next   = pick_idx;
                    bnd_next   = bound_arr[pick_idx];
                    tries_next = '0;
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (!req[idx]) begin
                    state_next = IDLE;
                end else if (bnd == '0 || cand < bnd) begin
                    accept     = 1'b1;
                    accept_val = cand;
                    state_next = GRANT;
                end else if (tries == LAST_TRY) begin
                    // Masking by bound-1 keeps the fallback strictly below bound.
                    accept     = 1'b1;
                    accept_val = cand & (bnd - OUT_W'(1));
                    state_next = GRANT;
                end else begin
                    tries_next = tries + TRY_W'(1);
                end
            end
            GRANT: begin
                last_next  = idx;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            last      <= IDX_W'(NREQ - 1);
            bnd       <= '0;
            tries     <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            last      <= last_next;
            bnd       <= bnd_next;
            tries     <= tries_next;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            if (accept) begin
                gnt       <= NREQ'(1) << idx;
                rnd_valid <= 1'b1;
                rnd_data  <= accept_val;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Directed bench for lfsr_rand_arbiter: LFSR sequence, seeding, latency, retry fallback,
// round-robin order, abandoned draws and asynchronous reset.
module tb_lfsr_rand_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic [27:0] seed;
    logic [3:0]  req;
    logic [31:0] bound;
    logic [3:0]  gnt;
    logic        rnd_valid;
    logic [7:0]  rnd_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n;

    logic [31:0] run_seq  [5] = '{32'd1, 32'd2, 32'd5, 32'd10, 32'd21};
    logic [31:0] rr_order [5] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
    logic [31:0] rr_lat   [5] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd3};

    lfsr_rand_arbiter #(.NREQ(4), .OUT_W(8), .MAX_TRIES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .bound     (bound),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until a grant appears or the budget runs out; n holds the cycle count.
    task automatic wait_gnt(input int budget);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 4'b0 && n < budget);
    endtask

    initial begin
        reset = 1'b1; seed_load = 1'b0; seed = '0; req = '0; bound = '0;
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(rnd_valid), 32'h0);
        check("rst_data", 32'(rnd_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_lfsr", 32'(dut.u_lfsr.state), 32'h0);

        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("lfsr_run", 32'(dut.u_lfsr.state), run_seq[i]);
            check("idle_outputs", 32'({gnt, rnd_valid, busy, rnd_data}), 32'h0);
        end

        // Loading the lock-up value must land on zero instead.
        seed_load = 1'b1; seed = 28'hFFFFFFF;
        tick();
        seed_load = 1'b0;
        check("lock_seed", 32'(dut.u_lfsr.state), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("after_lock", 32'(dut.u_lfsr.state), run_seq[i]);
        end

        // LFSR is 5 now; IDLE sees req, steps to 10, DRAW samples 0x0A.
        req = 4'b0001; bound = '0;
        tick();
        check("draw_busy", 32'(busy), 32'h1);
        check("draw_no_gnt", 32'(gnt), 32'h0);
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_valid", 32'(rnd_valid), 32'h1);
        check("first_data", 32'(rnd_data), 32'h0A);
        req = '0;
        tick();
        check("gnt_pulse", 32'({gnt, rnd_valid, busy}), 32'h0);

        // From seed 0xFE the draws are FD,FA,F5,EA,D5,AA,55,AA: all rejected by bound 1.
        seed_load = 1'b1; seed = 28'h00000FE;
        tick();
        seed_load = 1'b0; req = 4'b0001; bound = 32'h1;
        wait_gnt(20);
        check("retry_latency", 32'(n), 32'd9);
        check("retry_gnt", 32'(gnt), 32'h1);
        check("retry_fallback", 32'(rnd_data), 32'h0);
        req = '0; bound = '0;
        repeat (2) tick();

        reset = 1'b1;
        #1;
        check("async_rst_lfsr", 32'(dut.u_lfsr.state), 32'h0);
        tick();
        reset = 1'b0; req = 4'b1111; bound = '0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(12);
            check("rr_order", 32'(gnt), rr_order[i]);
            check("rr_spacing", 32'(n), rr_lat[i]);
        end
        req = '0;
        repeat (2) tick();

        // Requester 2 drops out mid-draw; pointer must stay at 0 so 2 beats 0 next.
        seed_load = 1'b1; seed = 28'h00000FE;
        tick();
        seed_load = 1'b0; req = 4'b0100; bound = 32'h0001_0000;
        tick();
        check("abandon_draw", 32'(busy), 32'h1);
        tick();
        check("abandon_retry", 32'({busy, gnt}), 32'h10);
        req = '0;
        tick();
        check("abandon_idle", 32'({busy, gnt, rnd_valid}), 32'h0);
        tick();
        check("abandon_quiet", 32'({busy, gnt, rnd_valid}), 32'h0);
        req = 4'b0101; bound = '0;
        wait_gnt(12);
        check("ptr_kept", 32'(gnt), 32'h4);
        check("ptr_kept_lat", 32'(n), 32'd2);
        req = '0;
        repeat (2) tick();

        req = 4'b1000; bound = '0;
        tick();
        check("pre_rst_draw", 32'(busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_outs", 32'({gnt, rnd_valid, busy}), 32'h0);
        check("mid_rst_lfsr", 32'(dut.u_lfsr.state), 32'h0);
        tick();
        reset = 1'b0; req = 4'b1001;
        wait_gnt(12);
        check("rst_priority", 32'(gnt), 32'h1);
        reset = 1'b1;
        #1;
        check("grant_rst_drop", 32'({gnt, rnd_valid, rnd_data}), 32'h0);
        reset = 1'b0; req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Shares one free-running 28-bit XNOR LFSR among NREQ requesters.
- Each requester asks for a random number below its own bound.
- The block arbitrates round-robin and draws by rejection sampling with a bounded retry count.
- It sits between the pseudo-random source and the game/test logic blocks that consume random values. Seeding is via a load port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OUT_W, 8, width of returned random value (1..16, must be <= 28).
- MAX_TRIES, 8, draws attempted before the fallback value is used (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- seed_load  input  1  load seed into LFSR this cycle.
- seed  input  28  seed value.
- req  input  NREQ  per-requester request level; held until gnt.
- bound  input  NREQ*OUT_W  per-requester exclusive upper bound, slice i = bound[i*OUT_W +: OUT_W]; 0 means full range.
- gnt  output  NREQ  one-hot, 1-cycle pulse marking the requester served.
- rnd_valid  output  1  pulses with gnt.
- rnd_data  output  OUT_W  random value, valid when rnd_valid.
- busy  output  1  high in DRAW or GRANT.

Behaviour:
- Reset state: lfsr=0, state IDLE, gnt=0, rnd_valid=0, rnd_data=0, busy=0, tries=0, last winner pointer=NREQ-1 (so requester 0 has first priority).
- LFSR step, every cycle out of reset: lfsr[27:1] <= lfsr[26:0]; lfsr[0] <= ~(lfsr[27]^lfsr[23]^lfsr[16]^lfsr[0]).
- LFSR lock-up state is all-ones; all-zero is legal.
- seed_load=1 overrides the step: lfsr <= seed. If seed == 28'hFFFFFFF, lfsr <= 0 instead.
- FSM IDLE:
  - If |req, pick the first set bit searching from last+1 upward, wrapping.
  - Latch idx and bound[idx]; tries=0; go DRAW.
  - Else stay.
- FSM DRAW: cand = lfsr[OUT_W-1:0], current register value before this cycle's update.
  - If req[idx]==0: abandon; go IDLE; pointer unchanged; no gnt.
  - Else if bound==0 or cand<bound: accept cand.
  - Else if tries==MAX_TRIES-1: accept cand & (bound-1). This is always < bound.
  - Else tries++ and stay in DRAW.
- FSM GRANT:
  - Registered outputs: rnd_data=accepted value, rnd_valid=1, gnt[idx]=1 for exactly this cycle.
  - last<=idx; go IDLE.
- Latency: req first seen in IDLE at cycle N; first draw at N+1; gnt at N+2 on first-draw accept. Each rejection adds 1 cycle. Maximum is N+1+MAX_TRIES.
- Throughput: one grant per at most MAX_TRIES+2 cycles. IDLE always spends one cycle, so back-to-back grants are never closer than 3 cycles apart.
- Simultaneous events:
  - seed_load during DRAW does not abort the draw; the cycle's sample uses the pre-load value.
  - req changes for other indices during DRAW are ignored until IDLE.
  - bound changes after latch are ignored.
- Reset mid-operation: immediate return to the reset state. Any pending grant is lost and gnt/rnd_valid drop asynchronously.
- OUT_W == 28 is not supported; the parameter check fails elaboration if OUT_W > 16.

Decomposition:
- Package lfsr_rand_pkg holds:
  - LFSR_W=28 and the tap indices 27/23/16/0.
  - LFSR_LOCK=28'hFFFFFFF.
  - State enum {IDLE, DRAW, GRANT}.
- One sub-module, lfsr28_seedable: clk, reset, seed_load, seed, state output. It contains the step and lock-up guard.
- The arbiter and FSM stay in the top.

Test Plan:
- Reset, then run 5 cycles with no req -> lfsr sequence 1, 2, 5, 10, 21; all outputs 0 throughout.
- seed_load with seed=28'hFFFFFFF -> lfsr=0 next cycle, then 1, 2, 5.
- req=4'b0001, bound=0 -> gnt=4'b0001 and rnd_valid at N+2; rnd_data equals lfsr[7:0] of the model at N+1.
- Requester 0 with bound=1 and seed=28'h00000FE, so every draw is >= 1 and is rejected MAX_TRIES times -> gnt at N+1+8; rnd_data = cand&0 = 0.
- req=4'b1111 held for 4 grants -> gnt order 0001, 0010, 0100, 1000, then 0001 again.
- Drop req[2] while it is in DRAW with a rejecting bound -> no gnt, FSM back to IDLE; next winner searched from last+1, pointer unchanged.
- Assert reset during DRAW -> gnt/rnd_valid/busy=0 immediately; lfsr=0; after release, requester 0 has priority.
